vga_sync_decoder: RTL and testbench

- Receive-side counterpart of the VGA timing generator: samples h_sync/v_sync on clock_25 and reconstructs pixel coordinates X/Y and the display-area flag.
- Checks every sync edge against 640x480@60 timing and reports lock, errors and frame starts.
- Used in the game testbench and loop-back checks. It rebuilds the pixel position from the sync outputs alone, then compares it with the tracker's X/Y.

---
 rtl/vga_sync_decoder.sv | 178 +++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing checker: rebuilds pixel X/Y from h_sync/v_sync alone,
// verifies every sync edge against the configured timing and reports lock state,
// timing violations and frame starts.
module vga_sync_decoder #(
    parameter int unsigned PIXEL_DISPLAY_BIT = 9,
    parameter int unsigned H_VISIBLE         = 640,
    parameter int unsigned H_FRONT           = 16,
    parameter int unsigned H_SYNC            = 96,
    parameter int unsigned H_BACK            = 48,
    parameter int unsigned V_VISIBLE         = 480,
    parameter int unsigned V_FRONT           = 10,
    parameter int unsigned V_SYNC            = 2,
    parameter int unsigned V_BACK            = 33,
    parameter bit          SYNC_ACTIVE       = 1'b0
) (
    input  logic                       clock_25,
    input  logic                       reset,
    input  logic                       h_sync,
    input  logic                       v_sync,
    output logic [PIXEL_DISPLAY_BIT:0] rx_x,
    output logic [PIXEL_DISPLAY_BIT:0] rx_y,
    output logic                       rx_display_area,
    output logic                       locked,
    output logic                       frame_start,
    output logic                       h_error,
    output logic                       v_error,
    output logic [7:0]                 error_count
);

    localparam int unsigned CW      = PIXEL_DISPLAY_BIT + 1;
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CW-1:0] HS_START = CW'(H_VISIBLE + H_FRONT);
    localparam logic [CW-1:0] HS_END   = CW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_VISIBLE + V_FRONT);
    localparam logic [CW-1:0] VS_END   = CW'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_VISIBLE);
    localparam logic [CW-1:0] V_VIS    = CW'(V_VISIBLE);
    localparam logic [CW-1:0] ONE      = CW'(1);

    typedef enum logic [1:0] {
        StSearchH,
        StSearchV,
        StVerify,
        StLocked
    } state_e;

    state_e        state_q, state_d;
    logic          hs_prev_q, vs_prev_q;
    logic [CW-1:0] hc_q, hc_d;
    logic [CW-1:0] vc_q, vc_d;
    logic [CW-1:0] rx_x_q, rx_y_q;
    logic          h_err_q, h_err_d;
    logic          v_err_q, v_err_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    // Position of the pixel whose sync samples are on the inputs this cycle
    logic [CW-1:0] pos_x, pos_y;

    logic h_rise, h_fall, v_rise, v_fall;
    logic h_fail, v_fail;

    // Edge detection against the previous sample of each sync
    always_comb begin
        h_rise = (h_sync == SYNC_ACTIVE) && (hs_prev_q != SYNC_ACTIVE);
        h_fall = (h_sync != SYNC_ACTIVE) && (hs_prev_q == SYNC_ACTIVE);
        v_rise = (v_sync == SYNC_ACTIVE) && (vs_prev_q != SYNC_ACTIVE);
        v_fall = (v_sync != SYNC_ACTIVE) && (vs_prev_q == SYNC_ACTIVE);
    end

    // Timing checks: h edges must coincide exactly with their expected columns;
    // v edges may only appear at their expected column/line
    always_comb begin
        h_fail = (h_rise != (hc_q == HS_START)) || (h_fall != (hc_q == HS_END));
        v_fail = (v_rise && !((hc_q == '0) && (vc_q == VS_START))) ||
                 (v_fall && !((hc_q == '0) && (vc_q == VS_END)));
    end

    // Acquisition FSM, realignment and error accounting
    always_comb begin
        state_d   = state_q;
        pos_x     = hc_q;
        pos_y     = vc_q;
        h_err_d   = 1'b0;
        v_err_d   = 1'b0;
        err_cnt_d = err_cnt_q;
        unique case (state_q)
            StSearchH: begin
                if (h_rise) begin
                    pos_x   = HS_START;
                    state_d = StSearchV;
                end
            end
            StSearchV: begin
                if (v_rise) begin
                    if (hc_q == '0) begin
                        pos_y   = VS_START;
                        state_d = StVerify;
                    end else begin
                        state_d = StSearchH;
                    end
                end
            end
            StVerify: begin
                // A v edge that passes the checks is by construction at hc=0, vc=VS_START
                if (h_fail || v_fail) begin
                    state_d = StSearchH;
                end else if (v_rise) begin
                    state_d = StLocked;
                end
            end
            StLocked: begin
                if (h_fail || v_fail) begin
                    state_d = StSearchH;
                    h_err_d = h_fail;
                    v_err_d = v_fail;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = StSearchH;
        endcase
    end

    // Counters advance from the (possibly realigned) current position
    always_comb begin
        hc_d = pos_x + ONE;
        vc_d = pos_y;
        if (pos_x == H_LAST) begin
            hc_d = '0;
            vc_d = (pos_y == V_LAST) ? '0 : pos_y + ONE;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock_25) begin
        if (reset) begin
            state_q   <= StSearchH;
            hs_prev_q <= ~SYNC_ACTIVE;
            vs_prev_q <= ~SYNC_ACTIVE;
            hc_q      <= '0;
            vc_q      <= '0;
            rx_x_q    <= '0;
            rx_y_q    <= '0;
            h_err_q   <= 1'b0;
            v_err_q   <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            hs_prev_q <= h_sync;
            vs_prev_q <= v_sync;
            hc_q      <= hc_d;
            vc_q      <= vc_d;
            rx_x_q    <= pos_x;
            rx_y_q    <= pos_y;
            h_err_q   <= h_err_d;
            v_err_q   <= v_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Status outputs are qualified by lock
    always_comb begin
        locked          = (state_q == StLocked);
        rx_x            = rx_x_q;
        rx_y            = rx_y_q;
        rx_display_area = locked && (rx_x_q < H_VIS) && (rx_y_q < V_VIS);
        frame_start     = locked && (rx_x_q == '0) && (rx_y_q == '0);
        h_error         = h_err_q;
        v_error         = v_err_q;
        error_count     = err_cnt_q;
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench for vga_sync_decoder using a shrunken raster so that many
// lock / fault / relock sequences fit in a short run.
module tb_vga_sync_decoder;

    localparam int PDB = 9;
    localparam int HV = 8, HF = 2, HS = 2, HB = 2;
    localparam int VV = 2, VF = 1, VS = 1, VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int HSS = HV + HF, HSE = HV + HF + HS;
    localparam int VSS = VV + VF, VSE = VV + VF + VS;
    localparam bit ACT = 1'b0;
    localparam int NF = 263;
    localparam int BUDGET = 80000;

    localparam int F_EARLY = 0, F_SHORT = 1, F_EXTRA = 2, F_BOTH = 3, F_RESET = 4;

    logic           clk = 1'b0;
    logic           rst, hs, vs;
    logic [PDB:0]   rx_x, rx_y;
    logic           rx_display_area, locked, frame_start, h_error, v_error;
    logic [7:0]     error_count;

    always #5 clk = ~clk;

    vga_sync_decoder #(
        .PIXEL_DISPLAY_BIT(PDB),
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_ACTIVE(ACT)
    ) dut (
        .clock_25(clk),
        .reset(rst),
        .h_sync(hs),
        .v_sync(vs),
        .rx_x(rx_x),
        .rx_y(rx_y),
        .rx_display_area(rx_display_area),
        .locked(locked),
        .frame_start(frame_start),
        .h_error(h_error),
        .v_error(v_error),
        .error_count(error_count)
    );

    typedef struct {
        bit         chk;
        logic [PDB:0] x;
        logic [PDB:0] y;
        bit         lk;
        bit         fs;
        bit         da;
        bit         he;
        bit         ve;
        logic [7:0] cnt;
    } exp_t;

    exp_t q[$];
    int   passed = 0;
    int   total = 0;
    bit   drv_done = 1'b0;

    task automatic push(input bit chk, input int xx, input int yy, input bit lk,
                        input bit fs, input bit da, input bit he, input bit ve,
                        input int c);
        exp_t e;
        e.chk = chk; e.x = (PDB+1)'(xx); e.y = (PDB+1)'(yy);
        e.lk = lk; e.fs = fs; e.da = da; e.he = he; e.ve = ve; e.cnt = 8'(c);
        q.push_back(e);
    endtask

    function automatic int fault_type(input int idx);
        if (idx < 5) return idx;
        return F_EARLY;
    endfunction

    // Stimulus: ideal raster with scheduled faults, plus reference expectations
    initial begin : drive
        int x, y, cyc, stage, ex, ey, cnt, locked_run, fault_idx, cur, min_run, ft;
        bit exp_locked, busy, line_active, extra_frame, extra_pending, finished;
        bit ph, pv, h_a, v_a, fh, fv, do_reset, trig;

        rst = 1'b1; hs = ~ACT; vs = ~ACT;
        for (int i = 0; i < 3; i++) begin
            push(1, 0, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
        end
        rst = 1'b0;
        x = 0; y = 0; cyc = 0; stage = 0; ex = 0; ey = 0; cnt = 0; locked_run = 0;
        fault_idx = 0; cur = 0; exp_locked = 0; busy = 0; line_active = 0;
        extra_frame = 0; extra_pending = 0; finished = 0; ph = 0; pv = 0;

        while (!finished) begin
            if (cyc >= BUDGET) begin
                total++;
                $display("FAIL timeout: cycles=%0d faults issued=%0d of %0d", cyc, fault_idx, NF);
                break;
            end
            do_reset = 0; fh = 0; fv = 0;
            min_run = (fault_idx < 5) ? 2 * FT : 1;

            if (!busy && fault_idx < NF && exp_locked && locked_run >= min_run) begin
                ft = fault_type(fault_idx);
                case (ft)
                    F_BOTH:  trig = (x == 0) && (y == VSS);
                    F_EXTRA: trig = (x == 0) && (y == 0);
                    F_RESET: trig = (x == 1) && (y == 0);
                    default: trig = (x == 0);
                endcase
                if (trig) begin
                    busy = 1; fault_idx++; cur = ft;
                    line_active = (ft == F_EARLY) || (ft == F_SHORT) || (ft == F_BOTH);
                    if (ft == F_EXTRA) extra_frame = 1;
                    if (ft == F_RESET) do_reset = 1;
                end
            end

            h_a = (x >= HSS) && (x < HSE);
            v_a = (y >= VSS) && (y < VSE);
            if (line_active) begin
                case (cur)
                    F_EARLY: if (x == HSS - 1) begin h_a = 1; fh = 1; end
                    F_SHORT: if (x == HSE - 1) begin h_a = 0; fh = 1; end
                    F_BOTH: begin
                        v_a = (x >= HSS - 1);
                        if (x == HSS - 1) begin h_a = 1; fh = 1; fv = 1; end
                    end
                    default: ;
                endcase
            end
            if (extra_pending && x == 0 && y == VSS) begin
                fv = 1; extra_pending = 0;
            end

            hs  = h_a ? ACT : ~ACT;
            vs  = v_a ? ACT : ~ACT;
            rst = do_reset;

            if (do_reset) begin
                push(1, 0, 0, 0, 0, 0, 0, 0, 0);
                exp_locked = 0; stage = 0; cnt = 0; locked_run = 0; busy = 0;
                ph = 0; pv = 0;
            end else begin
                if (exp_locked && (fh || fv)) begin
                    cnt = (cnt < 255) ? cnt + 1 : 255;
                    push(1, ex, ey, 0, 0, 0, fh, fv, cnt);
                    exp_locked = 0; stage = 0; locked_run = 0; busy = 0;
                end else if (exp_locked) begin
                    push(1, ex, ey, 1, (ex == 0 && ey == 0), (ex < HV && ey < VV), 0, 0, cnt);
                    locked_run++;
                end else begin
                    // Lock arrives on the second v assert edge after the first h assert edge
                    if (stage == 0 && h_a && !ph) stage = 1;
                    else if (stage == 1 && v_a && !pv) stage = 2;
                    else if (stage == 2 && v_a && !pv) begin
                        exp_locked = 1; ex = 0; ey = VSS; locked_run = 0;
                    end
                    if (exp_locked) push(1, ex, ey, 1, 0, (ex < HV && ey < VV), 0, 0, cnt);
                    else push(0, 0, 0, 0, 0, 0, 0, 0, cnt);
                end
                ph = h_a; pv = v_a;
            end

            if (ex == HT - 1) begin
                ex = 0; ey = (ey == VT - 1) ? 0 : ey + 1;
            end else begin
                ex++;
            end

            if (x == HT - 1) begin
                x = 0; line_active = 0;
                if ((y == VT - 1 && !extra_frame) || y == VT) begin
                    y = 0;
                    if (extra_frame) begin extra_frame = 0; extra_pending = 1; end
                end else begin
                    y++;
                end
            end else begin
                x++;
            end
            cyc++;
            finished = (fault_idx == NF) && !busy && exp_locked && (locked_run >= 2 * FT);
            @(negedge clk);
        end
        drv_done = 1'b1;
    end

    // Monitor: one expectation per captured sample, compared just after the edge
    initial begin : mon
        exp_t e;
        bit   ok;
        int   idx;
        idx = 0;
        while (!(drv_done && q.size() == 0)) begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                total++;
                ok = (locked === e.lk) && (frame_start === e.fs) &&
                     (rx_display_area === e.da) && (h_error === e.he) &&
                     (v_error === e.ve) && (error_count === e.cnt);
                if (e.chk && ((rx_x !== e.x) || (rx_y !== e.y))) ok = 0;
                if (ok) begin
                    passed++;
                end else begin
                    $display("FAIL sample%0d: got x=%0d y=%0d lk=%b fs=%b da=%b he=%b ve=%b cnt=%0d; want x=%0d y=%0d (chk=%0b) lk=%b fs=%b da=%b he=%b ve=%b cnt=%0d",
                             idx, rx_x, rx_y, locked, frame_start, rx_display_area, h_error,
                             v_error, error_count, e.x, e.y, e.chk, e.lk, e.fs, e.da, e.he,
                             e.ve, e.cnt);
                end
                idx++;
            end
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
